// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - instr/data arbiter onto one shared memory port with an in-order response FIFO
// Define CORE_MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over instr.
module core_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    unexp_rsp_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic {ST_ARB, ST_HOLD} state_t;

  state_t             state_q, state_d;
  logic               sel_q;        // source latched while waiting in HOLD: 0 = instr, 1 = data
  logic [CNT_W-1:0]   count_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic               fifo_q [MAX_OUTSTANDING];
  logic               pick, win, issue, push, pop, head;

`ifdef CORE_MEM_ARB_RR_EN
  logic prio_q;

  always_comb begin
    pick = data_req_i;
    if (instr_req_i && data_req_i) pick = prio_q;
  end
`else
  always_comb begin
    pick = data_req_i;
  end
`endif

  always_comb begin
    state_d = state_q;
    win     = sel_q;
    issue   = 1'b0;
    case (state_q)
      ST_ARB: begin
        win   = pick;
        issue = (count_q < CNT_MAX) && (instr_req_i || data_req_i);
        if (issue && !mem_gnt_i) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        issue = 1'b1;
        if (mem_gnt_i) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
    if (rst_i) issue = 1'b0;
  end

  always_comb begin
    mem_req_o   = issue;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (issue) begin
      if (win) begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_addr_o  = instr_addr_i;
        mem_be_o    = {BE_W{1'b1}};
      end
    end
  end

  // Responses return in grant order, so the FIFO head names the owner of each rvalid.
  assign head           = fifo_q[rd_ptr_q];
  assign push           = issue && mem_gnt_i;
  assign pop            = mem_rvalid_i && (count_q != '0) && !rst_i;
  assign instr_gnt_o    = push && !win;
  assign data_gnt_o     = push && win;
  assign instr_rvalid_o = pop && !head;
  assign data_rvalid_o  = pop && head;
  assign unexp_rsp_o    = mem_rvalid_i && (count_q == '0) && !rst_i;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= win;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_ARB;
      sel_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ARB) sel_q <= win;
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_q <= count_q + CNT_ONE;
      else if (pop && !push) count_q <= count_q - CNT_ONE;
    end
  end

`ifdef CORE_MEM_ARB_RR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)     prio_q <= 1'b0;
    else if (push) prio_q <= !win;
  end
`endif

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; byte enable width is DATA_WIDTH/8.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, range 1..8, maximum number of granted transfers still awaiting rvalid.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have ports:
  - clk_i  in  1  clock; all state on its rising edge.
  - rst_i  in  1  synchronous active-high reset.
  - instr_req_i / instr_gnt_o / instr_rvalid_o  in/out/out  1  instruction port handshake.
  - instr_addr_i  in  ADDR_WIDTH  instruction fetch address.
  - instr_rdata_o  out  DATA_WIDTH  fetch read data.
  - data_req_i / data_gnt_o / data_rvalid_o  in/out/out  1  data port handshake.
  - data_addr_i  in  ADDR_WIDTH  data address.
  - data_we_i  in  1  data write enable.
  - data_be_i  in  DATA_WIDTH/8  data byte enables.
  - data_wdata_i  in  DATA_WIDTH  write data.
  - data_rdata_o  out  DATA_WIDTH  data read data.
  - mem_req_o / mem_gnt_i / mem_rvalid_i  out/in/in  1  shared port toward the AXI bridge.
  - mem_addr_o  out  ADDR_WIDTH  shared address.
  - mem_we_o  out  1  shared write enable.
  - mem_be_o  out  DATA_WIDTH/8  shared byte enables.
  - mem_wdata_o  out  DATA_WIDTH  shared write data.
  - mem_rdata_i  in  DATA_WIDTH  shared read data.
  - unexp_rsp_o  out  1  one-cycle pulse on mem_rvalid_i with no outstanding transfer.

Function
REQ-006 SHALL implement FSM with two states: ARB and HOLD.
REQ-007 ARB: if count < MAX_OUTSTANDING and any request is pending, SHALL select a winner, drive mem_req_o=1 and the winner's fields in the same cycle (no added latency).
REQ-008 Instruction winner SHALL drive mem_we_o=0 and mem_be_o all ones; data winner passes data_we_i, data_be_i, data_wdata_i.
REQ-009 If mem_gnt_i=0 while mem_req_o=1, SHALL go to HOLD and keep the selected source until granted; mem_req_o stays 1 and the other requester is not considered.
REQ-010 HOLD -> ARB on the cycle mem_gnt_i=1.
REQ-011 winner_gnt_o SHALL equal mem_gnt_i AND mem_req_o AND the selected source; the non-selected gnt_o SHALL be 0.
REQ-012 Each grant SHALL push the source ID (0 = instr, 1 = data) into an ordered FIFO of depth MAX_OUTSTANDING; count tracks occupancy.
REQ-013 On mem_rvalid_i with count > 0, SHALL pulse rvalid_o of the FIFO-head source for one cycle, route mem_rdata_i to both rdata_o, and pop.
REQ-014 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-015 When count = MAX_OUTSTANDING, mem_req_o SHALL be 0 in ARB, even if mem_rvalid_i=1 in that cycle (no full bypass).
REQ-016 On mem_rvalid_i with count = 0, SHALL assert unexp_rsp_o for one cycle, with no rvalid_o and no pop.
REQ-017 FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-018 With no requests in ARB, mem_req_o SHALL be 0, and mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o SHALL be 0.

Reset
REQ-019 rst_i=1 at a clock edge SHALL set state=ARB, count=0, FIFO pointers=0 and priority pointer=instr.
REQ-020 During reset, all gnt_o, rvalid_o, mem_req_o and unexp_rsp_o SHALL be 0.
REQ-021 Reset during HOLD or with outstanding transfers SHALL discard them; later mem_rvalid_i SHALL be treated per REQ-016.

Configuration
REQ-022 With macro CORE_MEM_ARB_RR_EN defined, ARB SHALL use round-robin: after each grant, the priority pointer moves to the other source.
REQ-023 With CORE_MEM_ARB_RR_EN undefined, ARB SHALL use fixed priority, data over instr, and the priority pointer SHALL not exist.

Verification
REQ-024 Fixed priority, both req in ARB, mem_gnt_i=1 -> data_gnt_o=1, instr_gnt_o=0, FIFO head=1.
REQ-025 RR_EN, both requests held for 4 grants, mem_gnt_i=1 -> grant order instr, data, instr, data.
REQ-026 Data write addr 0x1000, be 4'b0011, mem_gnt_i low 3 cycles -> mem_req_o held with stable fields 3 cycles; instr request in that window not granted.
REQ-027 MAX_OUTSTANDING=2, two instr grants with no rvalid -> mem_req_o=0 for the third; rvalid with rdata 0xDEADBEEF -> instr_rvalid_o=1 and instr_rdata_o=0xDEADBEEF; third request issued next cycle.
REQ-028 Outstanding order instr, data; two rvalids -> instr_rvalid_o, then data_rvalid_o; count returns to 0.
REQ-029 rst_i during HOLD with one outstanding, then mem_rvalid_i=1 -> unexp_rsp_o=1 and no rvalid_o.
